// File: rtl/down_counter_timer.sv
// Loadable down-counter/timer with one-cycle done pulse and run status.
// Define AUTO_RELOAD_EN for periodic reload from the last loaded value.
module down_counter_timer #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             stop,
    output logic [WIDTH-1:0] counter_out,
    output logic             busy,
    output logic             done,
    output logic             zero
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             done_q, done_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            reload_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            done_q   <= done_d;
        end
    end

    // Priority: load > stop > decrement; done is low unless at terminal.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        done_d   = 1'b0;
        if (load) begin
            count_d  = load_value;
            reload_d = load_value;
            state_d  = (load_value != '0) ? RUN : IDLE;
        end else if (stop) begin
            state_d = IDLE;
        end else if (state_q == RUN && enable) begin
            if (count_q == ONE) begin
                done_d = 1'b1;
`ifdef AUTO_RELOAD_EN
                count_d = reload_q;
`else
                count_d = '0;
                state_d = IDLE;
`endif
            end else if (count_q != '0) begin
                count_d = count_q - ONE;
            end
        end
    end

    assign counter_out = count_q;
    assign busy        = (state_q == RUN);
    assign done        = done_q;
    assign zero        = (count_q == '0);

endmodule

// File: tb/tb_down_counter_timer.sv
// Randomized and directed bench for down_counter_timer against a
// behavioural model of the load/stop/count rules.
module tb_down_counter_timer;

    localparam int W = 4;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         enable = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] load_value = '0;
    logic         stop = 1'b0;
    logic [W-1:0] counter_out;
    logic         busy, done, zero;

    int checks = 0;
    int errors = 0;

    int  m_cnt, m_rl;
    bit  m_run, m_done;

    down_counter_timer #(.WIDTH(W)) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .load       (load),
        .load_value (load_value),
        .stop       (stop),
        .counter_out(counter_out),
        .busy       (busy),
        .done       (done),
        .zero       (zero)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_rl = 0; m_run = 0; m_done = 0;
    endtask

    task automatic model_edge();
        m_done = 0;
        if (load) begin
            m_cnt = int'(load_value);
            m_rl  = int'(load_value);
            m_run = (load_value != 0);
        end else if (stop) begin
            m_run = 0;
        end else if (m_run && enable && m_cnt > 0) begin
            if (m_cnt == 1) begin
                m_done = 1;
`ifdef AUTO_RELOAD_EN
                m_cnt = m_rl;
`else
                m_cnt = 0;
                m_run = 0;
`endif
            end else begin
                m_cnt = m_cnt - 1;
            end
        end
    endtask

    task automatic compare(input string tag);
        check({tag, ".cnt"}, int'(counter_out), m_cnt);
        check({tag, ".busy"}, int'(busy), int'(m_run));
        check({tag, ".done"}, int'(done), int'(m_done));
        check({tag, ".zero"}, int'(zero), int'(m_cnt == 0));
    endtask

    task automatic step(input string tag);
        @(posedge clock);
        model_edge();
        #1;
        compare(tag);
    endtask

    task automatic do_load(input int v);
        load = 1'b1; load_value = W'(v);
        step("load");
        load = 1'b0;
    endtask

    task automatic pulse_reset(input string tag);
        #2 reset = 1'b1;
        #1;
        model_reset();
        compare(tag);
        reset = 1'b0;
    endtask

    int dones;

    initial begin
        model_reset();
        reset = 1'b1;
        #1;
        compare("rst");
        #12 reset = 1'b0;
        @(negedge clock);
        enable = 1'b1;

        // load 5, count to zero
        do_load(5);
        check("t1.first", int'(counter_out), 5);
        dones = 0;
        for (int i = 0; i < 5; i++) begin
            step("t1");
            check("t1.seq", int'(counter_out), 4 - i);
            dones += int'(done);
        end
        check("t1.ndone", dones, 1);
        for (int i = 0; i < 4; i++) step("t1.tail");
`ifndef AUTO_RELOAD_EN
        check("t1.hold", int'(counter_out), 0);
`endif

        // enable gap at 3
        do_load(6);
        for (int i = 0; i < 3; i++) step("t2");
        enable = 1'b0;
        for (int i = 0; i < 4; i++) step("t2.gap");
        check("t2.held", int'(counter_out), 3);
        enable = 1'b1;
        for (int i = 0; i < 4; i++) step("t2.run");

        // restart mid-run
        do_load(9);
        for (int i = 0; i < 7; i++) step("t3");
        check("t3.at2", int'(counter_out), 2);
        do_load(12);
        check("t3.reload", int'(counter_out), 12);
        dones = 0;
        for (int i = 0; i < 14; i++) begin
            step("t3.run");
            dones += int'(done);
        end
`ifndef AUTO_RELOAD_EN
        check("t3.ndone", dones, 1);
`endif

        // load 0
        do_load(0);
        check("t4.busy", int'(busy), 0);
        for (int i = 0; i < 3; i++) step("t4");

        // async reset mid-run
        do_load(5);
        step("t5");
        check("t5.at4", int'(counter_out), 4);
        pulse_reset("t5.rst");
        for (int i = 0; i < 3; i++) step("t5.idle");

        // stop during run
        do_load(3);
        for (int i = 0; i < 5; i++) step("t6");
        stop = 1'b1;
        step("t6.stop");
        stop = 1'b0;
        for (int i = 0; i < 3; i++) step("t6.held");

        // max load value
        do_load(15);
        for (int i = 0; i < 17; i++) step("max");

        // random traffic
        for (int i = 0; i < 600; i++) begin
            enable     = ($urandom_range(3) != 0);
            load       = ($urandom_range(9) == 0);
            stop       = ($urandom_range(19) == 0);
            load_value = W'($urandom_range(15));
            if ($urandom_range(99) == 0) pulse_reset("rnd.rst");
            step("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
